// File: rtl/unified_mem_arbiter.sv
// Shares one single-port word-addressed memory between the fetch (IF) and data (DM) ports.
// One access at a time over a fixed read latency; one-cycle valid pulse per completed access.
//  state   | meaning
//  S_IDLE  | no access in flight; arbitrate and latch the winner's request
//  S_ISSUE | mem_en strobe for the granted access
//  S_WAIT  | read latency countdown; capture mem_rdata when the counter reaches zero
//  S_DONE  | one-cycle valid pulse to the owner, then back to idle
module unified_mem_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_valid,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_stall_if,
  output logic              o_stall_dm
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]  STARVE_TOP = SC_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_owner_dm;
  logic [SC_W-1:0]   r_starve;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_valid;
  logic              r_dm_valid;

  logic              w_any_req;
  logic              w_pick_if;

  assign w_any_req = i_if_req | i_dm_req;
  // DM normally wins; a saturated starvation count hands the slot to IF.
  assign w_pick_if = i_if_req & (~i_dm_req | (r_starve == STARVE_TOP));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_owner_dm  <= 1'b0;
      r_starve    <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_if_req || w_pick_if) begin
            r_starve <= '0;
          end else if (r_starve != STARVE_TOP) begin
            r_starve <= r_starve + SC_W'(1);
          end
          if (w_any_req) begin
            r_state    <= S_ISSUE;
            r_mem_en   <= 1'b1;
            r_owner_dm <= ~w_pick_if;
            if (w_pick_if) begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= i_if_addr;
            end else begin
              r_mem_we    <= i_dm_we;
              r_mem_addr  <= i_dm_addr;
              r_mem_wdata <= i_dm_wdata;
            end
          end
        end
        S_ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mem_we) begin
            r_state    <= S_DONE;
            r_if_valid <= ~r_owner_dm;
            r_dm_valid <= r_owner_dm;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata    <= i_mem_rdata;
            r_state    <= S_DONE;
            r_if_valid <= ~r_owner_dm;
            r_dm_valid <= r_owner_dm;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_if_rdata  = r_rdata;
  assign o_dm_rdata  = r_rdata;
  assign o_if_valid  = r_if_valid;
  assign o_dm_valid  = r_dm_valid;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_stall_if  = i_if_req & ~r_if_valid;
  assign o_stall_dm  = i_dm_req & ~r_dm_valid;

endmodule
